// File: rtl/dot_product_acc_if.sv
// -----------------------------------------------------------------------------
// dot_product_acc_if
// Stream-side bundle of the dot-product accumulator.
//   in_valid_i / in_ready_o / in_last_i / in_mode_i / in_0_i / in_1_i
//     : operand beat stream (N_LANES lanes per beat)
//   out_valid_o / out_ready_i / out_acc_o / out_ovf_o
//     : one result word per vector
// modport slave  : the accumulator's view
// modport master : the producer/consumer view (streamers, writeback, bench)
// -----------------------------------------------------------------------------
interface dot_product_acc_if #(
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8,
  parameter int N_LANES   = 8,
  parameter int ACC_SIZE  = 24
);
  logic                           in_valid_i;
  logic                           in_ready_o;
  logic                           in_last_i;
  logic [1:0]                     in_mode_i;
  logic [N_LANES*IN_SIZE_0-1:0]   in_0_i;
  logic [N_LANES*IN_SIZE_1-1:0]   in_1_i;
  logic                           out_valid_o;
  logic                           out_ready_i;
  logic [ACC_SIZE-1:0]            out_acc_o;
  logic                           out_ovf_o;

  modport slave (
    input  in_valid_i, in_last_i, in_mode_i, in_0_i, in_1_i, out_ready_i,
    output in_ready_o, out_valid_o, out_acc_o, out_ovf_o
  );

  modport master (
    output in_valid_i, in_last_i, in_mode_i, in_0_i, in_1_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_acc_o, out_ovf_o
  );
endinterface

// File: rtl/dot_product_acc.sv
// -----------------------------------------------------------------------------
// dot_product_acc
// Three-stage streaming dot-product accumulator.
//   S1: per-lane signed/unsigned products
//   S2: exact adder-tree sum of the lane products
//   S3: accumulator with wrap or saturation, sticky overflow, result register
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : dot_product_acc_if.slave (operand stream in, result stream out)
// Parameters: IN_SIZE_0/IN_SIZE_1 lane widths, N_LANES (power of two, >= 2),
// ACC_SIZE (>= SUM_W), SATURATE (1 = clamp, 0 = wrap).
// -----------------------------------------------------------------------------
module dot_product_acc #(
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8,
  parameter int N_LANES   = 8,
  parameter int ACC_SIZE  = 24,
  parameter bit SATURATE  = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  dot_product_acc_if.slave   bus
);

  localparam int PROD_W = IN_SIZE_0 + IN_SIZE_1 + 1;
  localparam int SUM_W  = PROD_W + $clog2(N_LANES);
  localparam int EXT_W  = ACC_SIZE + 1;

  localparam logic signed [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

  // Whole pipeline moves together; it only freezes while a finished result
  // is waiting for a consumer that is not ready.
  logic advance;

  // S1 state
  logic                     s1_valid, s1_last;
  logic signed [PROD_W-1:0] s1_prod [N_LANES];
  // S2 state
  logic                     s2_valid, s2_last;
  logic signed [SUM_W-1:0]  s2_sum;
  // S3 state
  logic signed [ACC_SIZE-1:0] acc_q;
  logic                       ovf_q;
  logic                       first_q;
  logic                       out_valid_q;
  logic        [ACC_SIZE-1:0] out_acc_q;
  logic                       out_ovf_q;

  assign advance        = !out_valid_q || bus.out_ready_i;
  assign bus.in_ready_o = advance;

  // ---------------------------------------------------------------------------
  // Lane multipliers. Each operand gets one extra bit (sign or zero per mode)
  // and is then carried at PROD_W, where every mode's product is exact.
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod [N_LANES];

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic                     sx0, sx1;
    logic signed [PROD_W-1:0] op0, op1;
    assign sx0     = bus.in_mode_i[0] & bus.in_0_i[i*IN_SIZE_0 + IN_SIZE_0 - 1];
    assign sx1     = bus.in_mode_i[1] & bus.in_1_i[i*IN_SIZE_1 + IN_SIZE_1 - 1];
    assign op0     = {{(PROD_W-IN_SIZE_0){sx0}}, bus.in_0_i[i*IN_SIZE_0 +: IN_SIZE_0]};
    assign op1     = {{(PROD_W-IN_SIZE_1){sx1}}, bus.in_1_i[i*IN_SIZE_1 +: IN_SIZE_1]};
    assign prod[i] = op0 * op1;
  end

  // ---------------------------------------------------------------------------
  // Balanced adder tree: pairwise in-place reduction, log2(N_LANES) levels.
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0] lvl [N_LANES];
  logic signed [SUM_W-1:0] tree_sum;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output
    // first, so each path is fully specified and no latch is inferred.
    for (int i = 0; i < N_LANES; i++) lvl[i] = SUM_W'(s1_prod[i]);
    for (int s = 1; s < N_LANES; s = s * 2)
      for (int k = 0; k < N_LANES; k = k + 2 * s)
        lvl[k] = lvl[k] + lvl[k+s];
    tree_sum = lvl[0];
  end

  // ---------------------------------------------------------------------------
  // Accumulator update. A first beat starts from zero with a clean flag.
  // Overflow is detected by the two top bits of the one-bit-wider sum.
  // ---------------------------------------------------------------------------
  logic signed [ACC_SIZE-1:0] acc_base;
  logic signed [EXT_W-1:0]    exact;
  logic                       ovf_now;
  logic signed [ACC_SIZE-1:0] acc_next;
  logic                       ovf_next;

  always_comb begin
    acc_base = first_q ? '0 : acc_q;
    exact    = EXT_W'(acc_base) + EXT_W'(s2_sum);
    ovf_now  = exact[EXT_W-1] != exact[EXT_W-2];
    acc_next = exact[ACC_SIZE-1:0];
    if (ovf_now && SATURATE) acc_next = exact[EXT_W-1] ? ACC_MIN : ACC_MAX;
    ovf_next = (!first_q && ovf_q) || ovf_now;
  end

  // ---------------------------------------------------------------------------
  // Control and accumulator state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: registers use non-blocking '<=' so every flop samples the values
    // from before the edge, independent of statement order.
    if (!rst_ni) begin
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s2_valid    <= 1'b0;
      s2_last     <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (advance) begin
        s1_valid <= bus.in_valid_i;
        s1_last  <= bus.in_valid_i && bus.in_last_i;
        s2_valid <= s1_valid;
        s2_last  <= s1_valid && s1_last;
        if (s2_valid) begin
          acc_q   <= acc_next;
          ovf_q   <= ovf_next;
          first_q <= s2_last;
        end
      end
      if (out_valid_q && bus.out_ready_i) out_valid_q <= 1'b0;
      // A new result in the same edge as a consume overrides the clear above.
      if (advance && s2_valid && s2_last) begin
        out_valid_q <= 1'b1;
        out_acc_q   <= acc_next;
        out_ovf_q   <= ovf_next;
      end
    end
  end

  // NOTE: datapath registers carry no reset; their valid bits qualify them,
  // which keeps the product array and sum free of reset fan-out.
  always_ff @(posedge clk_i) begin
    if (advance) begin
      if (bus.in_valid_i) s1_prod <= prod;
      if (s1_valid)       s2_sum  <= tree_sum;
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.out_acc_o   = out_acc_q;
  assign bus.out_ovf_o   = out_ovf_q;

endmodule

// File: doc/dot_product_acc.md
# dot_product_acc

Pipelined, parametrised signed/unsigned dot-product accumulator, the streaming successor of the fixed 8-lane `baseline` MAC. Each accepted beat multiplies N_LANES operand pairs and reduces them through an adder tree. Beats are accumulated until a beat flagged last, and the result is returned as one full-width word. Overflow handling is selectable. The block sits between the operand streamers and the result writeback, with valid/ready handshakes on both sides.

## Interface
- IN_SIZE_0, 4, width of each operand-0 lane
- IN_SIZE_1, 8, width of each operand-1 lane
- N_LANES, 8, lanes per beat; must be a power of two, ≥2
- ACC_SIZE, 24, accumulator/result width; must be ≥ SUM_W = IN_SIZE_0+IN_SIZE_1+1+$clog2(N_LANES)
- SATURATE, 1, 1 = clamp the accumulator to the signed ACC_SIZE range; 0 = two's-complement wrap
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  beat valid
- in_ready_o  out  1  beat accepted when in_valid_i && in_ready_o at rising edge
- in_last_i  in  1  beat closes the current vector
- in_mode_i  in  2  bit0: operand 0 signed(1)/unsigned(0); bit1: same for operand 1; sampled per beat
- in_0_i  in  N_LANES×IN_SIZE_0  operand-0 lanes, lane i at [i*IN_SIZE_0 +: IN_SIZE_0]
- in_1_i  in  N_LANES×IN_SIZE_1  operand-1 lanes, same packing
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result consumed when out_valid_o && out_ready_i at rising edge
- out_acc_o  out  ACC_SIZE  signed vector result
- out_ovf_o  out  1  sticky per-vector overflow flag

## Operation
- Operand extension: each lane operand is extended by 1 bit, sign- or zero-extended per its in_mode_i bit. The product is signed, PROD_W = IN_SIZE_0+IN_SIZE_1+1 bits, and is exact in every mode.
- S1 register: N_LANES products, plus last flag and valid bit.
- S2 register: adder-tree sum, signed SUM_W bits, exact; plus last flag and valid bit.
- S3, accumulator:
  - exact = acc + sign-extended sum, computed at ACC_SIZE+1 bits.
  - Overflow when exact is outside [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1].
  - SATURATE=1: acc takes the clamped value. SATURATE=0: acc takes the low ACC_SIZE bits.
  - An overflow sets the sticky ovf bit.
- First-beat rule: an internal `first` flag is set at reset and after every last beat. On a first beat, acc = sum (cleared before adding) and ovf restarts at 0.
- Result: when an S3 beat has last=1, out_acc_o takes the post-update acc, out_ovf_o takes the post-update ovf, and out_valid_o is set. The result register holds until handshaked.
- Single vector of one beat: in_last_i=1 on the first beat is legal.
- Stall: advance = !out_valid_o || out_ready_i.
  - in_ready_o = advance (combinational from out_ready_i).
  - While advance=0, every pipeline register holds, including valid bits and acc.
  - While advance=1, bubbles (in_valid_i=0) propagate as valid=0 and do not touch acc.
- Simultaneous consume and new result: if out_ready_i=1 while a last beat reaches S3, the new result replaces the old in that same edge, and out_valid_o stays 1.
- Reset, any time (mid-vector or with a result pending):
  - All valid bits = 0, acc = 0, ovf = 0, first = 1.
  - out_valid_o = 0, out_acc_o = 0, out_ovf_o = 0.
  - in_ready_o = 1 (out_valid_o = 0).
  - Partial vectors are discarded.

## Timing
- Latency: a last beat accepted at edge T reaches S1 at T, S2 at T+1, and the output at T+2. out_valid_o is high from T+2.
- Throughput: one beat per cycle with no stall, including back-to-back vectors.
- No combinational path from in_*_i data to any output. The only combinational path is out_ready_i → in_ready_o.
- Outputs are stable while out_valid_o=1 && out_ready_i=0.

## Test plan
- Signed corner cases, mode=2'b11, one beat with last, all lanes 7×127 → out_acc_o=7112, ovf=0, out_valid_o rises exactly 2 edges after acceptance. Repeat with all lanes (-8)×(-128), 4 beats → 32768.
- Mixed sign: lanes (-8)×127 → -8128. Zeros → 0. Unsigned mode 2'b00, lanes 15×255, one beat → 30600. Mode 2'b01 with in_0=4'hF (-1), in_1=8'hFF (255) → -2040.
- Saturation, SATURATE=1, mode 2'b00, lanes 15×255:
  - 274 beats → 8384400, ovf=0.
  - 275 beats → 8388607, ovf=1.
  - Following vector of 1 beat → 30600, ovf=0.
- Backpressure: out_ready_i=0 while 3 single-beat vectors stream in.
  - in_ready_o drops once the result register is full and the pipeline is full; no beat is lost.
  - Releasing out_ready_i delivers the 3 results in order, unchanged.
- Reset mid-operation: assert rst_ni low for 1 cycle in the middle of a 4-beat vector.
  - All outputs go to 0 asynchronously.
  - The next 1-beat vector of 7×127 returns 7112, with no residue from the aborted vector.
- Random regression: 1000 vectors with random length 1–16, random modes, random in_valid_i and out_ready_i gaps. Compare against a bit-exact reference model, including ovf.
